// File: rtl/mr_pkg.sv
// Shared definitions for the memory-read pipeline stage.
//   mr_state_e     : stage occupancy state (EMPTY / WAIT / FULL)
//   MEMSEL_D/S     : which operand the read data replaces
//   TIMEOUT_FILL_B : bit replicated across an operand abandoned on timeout
package mr_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StWait  = 2'b01,
    StFull  = 2'b10
  } mr_state_e;

  localparam logic MEMSEL_D = 1'b0;
  localparam logic MEMSEL_S = 1'b1;

  localparam logic TIMEOUT_FILL_B = 1'b1;

endpackage

// File: rtl/mr_wait_timer.sv
// Read-wait cycle counter for the memory-read stage.
// Ports:
//   clk    : clock
//   r      : synchronous active-low reset
//   en     : count this cycle
//   clr    : return to zero (wins over en)
//   expire : count has reached TIMEOUT-1
module mr_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic r,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!r) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire = (count_q == CntLast);

endmodule

// File: rtl/mr_stage_pipe.sv
// Memory-read pipeline stage: holds one entry between address generation and
// execute, issues an optional multi-cycle memory read, substitutes the read
// data into one operand, and presents the entry downstream.
// Ports:
//   clk, r                       : clock, synchronous active-low reset
//   in_v/in_re/in_memsel/in_addr : upstream entry valid, needs read, target operand, address
//   in_dval/in_sval/in_ctrl      : upstream operands and pass-through control
//   in_stall                     : upstream must hold its entry
//   mem_re/mem_addr              : memory read request and address
//   mem_done/mem_data            : read completion and data
//   out_v/out_addr/out_dval/out_sval/out_ctrl : entry presented to execute
//   out_stall                    : execute cannot accept
//   flush                        : squash held entry
//   err                          : sticky read-timeout flag
module mr_stage_pipe
  import mr_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CTRL_W  = 80,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              r,
  input  logic              in_v,
  input  logic              in_re,
  input  logic              in_memsel,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_dval,
  input  logic [DATA_W-1:0] in_sval,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              in_stall,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_v,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_dval,
  output logic [DATA_W-1:0] out_sval,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              out_stall,
  input  logic              flush,
  output logic              err
);

  localparam logic [DATA_W-1:0] FillVal = {DATA_W{TIMEOUT_FILL_B}};

  mr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dval_q, dval_d;
  logic [DATA_W-1:0] sval_q, sval_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              memsel_q, memsel_d;
  logic              err_q, err_d;

  logic is_wait;
  logic accept;
  logic expire;
  logic timer_clr;

  assign is_wait  = (state_q == StWait);
  assign in_stall = flush | is_wait | ((state_q == StFull) & out_stall);
  assign accept   = in_v & ~in_stall;

  // Clear on leaving WAIT so the next read starts counting from zero.
  assign timer_clr = flush | (is_wait & (mem_done | expire));

  mr_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .r      (r),
    .en     (is_wait),
    .clr    (timer_clr),
    .expire (expire)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dval_d   = dval_q;
    sval_d   = sval_q;
    ctrl_d   = ctrl_q;
    memsel_d = memsel_q;
    err_d    = err_q;

    if (accept) begin
      // Covers both EMPTY and FULL-with-handoff (back-to-back, no bubble).
      addr_d   = in_addr;
      dval_d   = in_dval;
      sval_d   = in_sval;
      ctrl_d   = in_ctrl;
      memsel_d = in_memsel;
      state_d  = in_re ? StWait : StFull;
    end else if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: state_d = StEmpty;
        StWait: begin
          if (mem_done) begin
            if (memsel_q == MEMSEL_S) sval_d = mem_data;
            else                      dval_d = mem_data;
            state_d = StFull;
          end else if (expire) begin
            if (memsel_q == MEMSEL_S) sval_d = FillVal;
            else                      dval_d = FillVal;
            err_d   = 1'b1;
            state_d = StFull;
          end
        end
        StFull: begin
          if (!out_stall) state_d = StEmpty;
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      state_q  <= StEmpty;
      addr_q   <= '0;
      dval_q   <= '0;
      sval_q   <= '0;
      ctrl_q   <= '0;
      memsel_q <= MEMSEL_D;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dval_q   <= dval_d;
      sval_q   <= sval_d;
      ctrl_q   <= ctrl_d;
      memsel_q <= memsel_d;
      err_q    <= err_d;
    end
  end

  assign mem_re   = is_wait;
  assign mem_addr = addr_q;
  assign out_v    = (state_q == StFull);
  assign out_addr = addr_q;
  assign out_dval = dval_q;
  assign out_sval = sval_q;
  assign out_ctrl = ctrl_q;
  assign err      = err_q;

endmodule

// File: doc/mr_stage_pipe.md
Name: mr_stage_pipe

Overview:
- Parametrised memory-read pipeline stage that sits between address generation and execute.
- Replaces the fixed-width MR latches, which had no stall path, with one registered entry.
- Handles a valid/stall handshake on both sides, a multi-cycle memory read with completion handshake, operand substitution, flush, and read timeout detection.
- Non-memory control fields are carried through as one packed bundle.

Parameters:
- DATA_W, 32, operand and memory data width
- ADDR_W, 32, memory address width
- CTRL_W, 80, width of packed pass-through control (we, modrm, alusel, cc, ccw, ...)
- TIMEOUT, 16, maximum cycles in WAIT before the read is abandoned (>=2)

Ports:
- clk  in  1  clock; all state updates on posedge
- r  in  1  reset, synchronous, active-low
- in_v  in  1  upstream entry valid
- in_re  in  1  entry requires memory read
- in_memsel  in  1  0: read data replaces dval; 1: replaces sval
- in_addr  in  ADDR_W  effective address from AG
- in_dval  in  DATA_W  destination operand
- in_sval  in  DATA_W  source operand
- in_ctrl  in  CTRL_W  pass-through control bundle
- in_stall  out  1  upstream must hold its entry
- mem_re  out  1  memory read request
- mem_addr  out  ADDR_W  memory read address
- mem_done  in  1  read complete, mem_data valid this cycle
- mem_data  in  DATA_W  read data
- out_v  out  1  entry valid to EX
- out_addr  out  ADDR_W  entry address
- out_dval  out  DATA_W  dval after substitution
- out_sval  out  DATA_W  sval after substitution
- out_ctrl  out  CTRL_W  pass-through control
- out_stall  in  1  EX cannot accept
- flush  in  1  synchronous squash of held entry
- err  out  1  sticky read-timeout flag

Behaviour:
- Clock and reset: one clock (clk); synchronous active-low reset (r).
- Reset (r=0 at posedge):
  - state=EMPTY, timer=0, err=0.
  - out_v=0, mem_re=0; out_addr/out_dval/out_sval/out_ctrl=0.
  - Reset overrides flush and all inputs.
- States:
  - EMPTY: no entry held.
  - WAIT: entry held, read outstanding.
  - FULL: entry held and presented.
- Combinational outputs:
  - mem_re = (state==WAIT). mem_addr = held addr.
  - out_v = (state==FULL).
  - in_stall = flush | (state==WAIT) | (state==FULL & out_stall).
- Accept: at posedge with in_v=1 and in_stall=0, capture the input bundle.
  - Next state is WAIT if in_re=1, else FULL.
  - FULL with out_stall=0 hands off and accepts in the same cycle (back-to-back, no bubble).
  - In FULL with out_stall=0 and no accept: next state EMPTY.
- In FULL with out_stall=1: all outputs hold stable.
- WAIT:
  - timer increments each cycle in WAIT.
  - mem_done=1: mem_data is written into dval (memsel=0) or sval (memsel=1); timer clears; next state FULL.
  - Earliest completion: accept at edge N, done at edge N+1, out_v high from N+1.
  - Timeout: timer==TIMEOUT-1 with mem_done=0 means substitute {DATA_W{1'b1}}, set err=1 (sticky until reset), next state FULL.
  - mem_done with timeout in the same cycle: done wins, err unchanged.
- mem_done outside WAIT is ignored.
- flush=1 at posedge:
  - Next state EMPTY, timer clears.
  - No accept that cycle, since in_stall is forced high.
  - A read in flight is abandoned: mem_re drops next cycle; a late mem_done is ignored.
- Non-read entries never assert mem_re.
- in_memsel and in_ctrl are latched at accept only.

Decomposition:
- Shared package mr_pkg:
  - state encoding (EMPTY=2'b00, WAIT=2'b01, FULL=2'b10)
  - MEMSEL_D=1'b0, MEMSEL_S=1'b1
  - timeout fill constant
- One sub-module, mr_wait_timer: clog2(TIMEOUT)-bit counter.
  - Inputs: en, clr.
  - Output: expire = (count==TIMEOUT-1).
  - Uses the same synchronous active-low reset.

Test Plan:
- Reset with r=0 for 2 cycles while in_v=1 -> out_v=0, mem_re=0, err=0, in_stall=0 after release.
- Single non-read entry, in_re=0, dval=32'h0000ABCD, sval=1 -> out_v one edge later with identical values, mem_re never 1.
- Read entry, addr=32'h0DEF0002, memsel=1, mem_done after 3 cycles with data=32'h12345678 -> mem_re high 3 cycles, in_stall high, out_sval=32'h12345678, out_dval unchanged.
- Back-to-back 4 non-read entries with out_stall=0 -> out_v continuously high, one entry per cycle, in order. Asserting out_stall for 2 cycles -> outputs frozen, in_stall high, no entry lost or duplicated.
- Read with mem_done never asserted, TIMEOUT=16 -> after 16 WAIT cycles the entry exits with the substituted operand=32'hFFFFFFFF and err=1, which stays 1 across later entries until reset.
- flush during WAIT, then mem_done next cycle -> out_v stays 0, state EMPTY, mem_done ignored. Following entry is accepted normally.
